// File: rtl/pc_gen_pkg.sv
// Shared types and constants for the IF-stage program-counter generator.
// Fetch state names and the control-level encodings used by the pipeline.
package pc_gen_pkg;

  localparam int   PC_ADDR_W    = 32;
  localparam logic CHIP_ENABLE  = 1'b1;
  localparam logic CHIP_DISABLE = 1'b0;
  localparam logic STOP         = 1'b1;
  localparam logic NO_STOP      = 1'b0;
  localparam logic BRANCH       = 1'b1;
  localparam logic NOT_BRANCH   = 1'b0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } pc_state_e;

endpackage

// File: rtl/pc_gen_redirect_buf.sv
// One-entry pending-branch buffer: holds a taken branch target that could not
// be applied yet because the current request was not accepted.
module pc_redirect_buf #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set,
  input  logic              clr,
  input  logic [ADDR_W-1:0] set_addr,
  output logic              pend_vld,
  output logic [ADDR_W-1:0] pend_addr
);

  // clr and set are never asserted together by the top; clr still wins so
  // a flush can never leave a stale branch behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_vld  <= 1'b0;
      pend_addr <= '0;
    end else if (clr) begin
      pend_vld  <= 1'b0;
    end else if (set) begin
      pend_vld  <= 1'b1;
      pend_addr <= set_addr;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// IF-stage program counter: drives the fetch address and request-valid (ce),
// with stall, branch redirect, flush redirect and a pending-branch buffer.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int              ADDR_W       = PC_ADDR_W,
  parameter int              INC          = 4,
  parameter int              ALIGN_BITS   = 2,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
  parameter int              STALL_W      = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  new_pc,
  input  logic               branch_flag,
  input  logic [ADDR_W-1:0]  branch_addr,
  input  logic               if_ready,
  output logic [ADDR_W-1:0]  pc,
  output logic               ce
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = {ADDR_W{1'b1}} << ALIGN_BITS;

  pc_state_e         state_q, state_d;
  logic              adv;
  logic [ADDR_W-1:0] next_pc;
  logic              buf_set, buf_clr;
  logic              pend_vld;
  logic [ADDR_W-1:0] pend_addr;
  logic              unused_stall;

  // Only stall[0] controls this stage; the other bits belong to later stages.
  assign unused_stall = ^stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == ST_IDLE) state_d = ST_RUN;
  end

  assign ce  = (state_q == ST_RUN) ? CHIP_ENABLE : CHIP_DISABLE;
  assign adv = ce & if_ready & (stall[0] == NO_STOP);

  // Priority: flush, accepted branch, deferred branch, pending redirect, +INC.
  always_comb begin
    next_pc = pc;
    buf_set = 1'b0;
    buf_clr = 1'b0;
    if (ce) begin
      if (flush) begin
        next_pc = new_pc & ALIGN_MASK;
        buf_clr = 1'b1;
      end else if (branch_flag == BRANCH && adv) begin
        next_pc = branch_addr & ALIGN_MASK;
        buf_clr = 1'b1;
      end else if (branch_flag == BRANCH) begin
        buf_set = 1'b1;
      end else if (pend_vld && adv) begin
        next_pc = pend_addr;
        buf_clr = 1'b1;
      end else if (adv) begin
        next_pc = pc + ADDR_W'(INC);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc <= RESET_VECTOR;
    else     pc <= next_pc;
  end

  pc_redirect_buf #(
    .ADDR_W(ADDR_W)
  ) u_redirect_buf (
    .clk      (clk),
    .rst      (rst),
    .set      (buf_set),
    .clr      (buf_clr),
    .set_addr (branch_addr & ALIGN_MASK),
    .pend_vld (pend_vld),
    .pend_addr(pend_addr)
  );

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: three configurations (32-bit default, 16-bit, 16-bit INC=1
// no-align) share stimulus and are checked against a rule-level model.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        branch_flag;
  logic [31:0] branch_addr;
  logic        if_ready;
  logic [31:0] pc_a;
  logic [15:0] pc_b, pc_c;
  logic        ce_a, ce_b, ce_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_gen dut_a (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .new_pc(new_pc),
    .branch_flag(branch_flag), .branch_addr(branch_addr), .if_ready(if_ready),
    .pc(pc_a), .ce(ce_a)
  );

  pc_gen #(.ADDR_W(16)) dut_b (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .new_pc(new_pc[15:0]),
    .branch_flag(branch_flag), .branch_addr(branch_addr[15:0]), .if_ready(if_ready),
    .pc(pc_b), .ce(ce_b)
  );

  pc_gen #(.ADDR_W(16), .INC(1), .ALIGN_BITS(0)) dut_c (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .new_pc(new_pc[15:0]),
    .branch_flag(branch_flag), .branch_addr(branch_addr[15:0]), .if_ready(if_ready),
    .pc(pc_c), .ce(ce_c)
  );

  // ---------------- reference model ----------------
  typedef struct {
    logic        ce;
    logic [31:0] pc;
    logic        pv;
    logic [31:0] pa;
  } mstate_t;

  mstate_t m[3];
  int cfg_aw[3]  = '{32, 16, 16};
  int cfg_inc[3] = '{4, 4, 1};
  int cfg_ab[3]  = '{2, 2, 0};

  function automatic mstate_t model_reset();
    mstate_t s;
    s.ce = 1'b0; s.pc = 32'h0; s.pv = 1'b0; s.pa = 32'h0;
    return s;
  endfunction

  function automatic mstate_t model_step(mstate_t s, int aw, int inc, int ab,
                                         logic st0, logic fl, logic [31:0] np,
                                         logic br, logic [31:0] ba, logic rdy);
    mstate_t n;
    longint unsigned mask;
    longint unsigned amask;
    logic go;
    n     = s;
    mask  = (64'd1 << aw) - 64'd1;
    amask = mask & ~((64'd1 << ab) - 64'd1);
    go    = s.ce && rdy && !st0;
    if (!s.ce) begin
      n.ce = 1'b1;
    end else if (fl) begin
      n.pc = 32'(np & amask); n.pv = 1'b0;
    end else if (br && go) begin
      n.pc = 32'(ba & amask); n.pv = 1'b0;
    end else if (br) begin
      n.pv = 1'b1; n.pa = 32'(ba & amask);
    end else if (s.pv && go) begin
      n.pc = s.pa; n.pv = 1'b0;
    end else if (go) begin
      n.pc = 32'((longint'(s.pc) + inc) & mask);
    end
    return n;
  endfunction

  // ---------------- scoreboard helpers ----------------
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_models();
    chk("a_pc", pc_a, m[0].pc);
    chk("a_ce", {31'b0, ce_a}, {31'b0, m[0].ce});
    chk("b_pc", {16'b0, pc_b}, m[1].pc);
    chk("b_ce", {31'b0, ce_b}, {31'b0, m[1].ce});
    chk("c_pc", {16'b0, pc_c}, m[2].pc);
    chk("c_ce", {31'b0, ce_c}, {31'b0, m[2].ce});
  endtask

  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 3; k++)
      m[k] = model_step(m[k], cfg_aw[k], cfg_inc[k], cfg_ab[k], stall[0], flush,
                        new_pc, branch_flag, branch_addr, if_ready);
    #1;
    chk_models();
  endtask

  task automatic drive(logic st, logic fl, logic [31:0] np, logic br,
                       logic [31:0] ba, logic rdy);
    stall       = {5'($urandom_range(0, 31)), st};
    flush       = fl;
    new_pc      = np;
    branch_flag = br;
    branch_addr = ba;
    if_ready    = rdy;
  endtask

  task automatic pulse_reset();
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) m[k] = model_reset();
    chk("rst_a_pc", pc_a, 32'h0);
    chk("rst_a_ce", {31'b0, ce_a}, 32'h0);
    chk_models();
    rst = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        st;
    logic        fl;
    logic [31:0] np;
    logic        br;
    logic [31:0] ba;
    logic        rdy;
    logic [31:0] exp_pc;
    logic        exp_ce;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t row(logic st, logic fl, logic [31:0] np, logic br,
                               logic [31:0] ba, logic rdy, logic [31:0] ep);
    vec_t v;
    v.st = st; v.fl = fl; v.np = np; v.br = br; v.ba = ba; v.rdy = rdy;
    v.exp_pc = ep; v.exp_ce = 1'b1;
    return v;
  endfunction

  initial begin
    // reset release and sequential run
    tbl.push_back(row(0, 0, 0, 0, 0, 1, 32'h000));
    tbl.push_back(row(0, 0, 0, 0, 0, 1, 32'h004));
    tbl.push_back(row(0, 0, 0, 0, 0, 1, 32'h008));
    tbl.push_back(row(0, 0, 0, 0, 0, 1, 32'h00C));
    tbl.push_back(row(0, 0, 0, 0, 0, 1, 32'h010));
    // stall holds
    for (int i = 0; i < 3; i++) tbl.push_back(row(1, 0, 0, 0, 0, 1, 32'h010));
    tbl.push_back(row(0, 0, 0, 0, 0, 1, 32'h014));
    // not-ready holds
    for (int i = 0; i < 3; i++) tbl.push_back(row(0, 0, 0, 0, 0, 0, 32'h014));
    tbl.push_back(row(0, 0, 0, 0, 0, 1, 32'h018));
    tbl.push_back(row(0, 0, 0, 0, 0, 1, 32'h01C));
    tbl.push_back(row(0, 0, 0, 0, 0, 1, 32'h020));
    // branch while stalled is deferred
    tbl.push_back(row(1, 0, 0, 1, 32'h103, 1, 32'h020));
    tbl.push_back(row(1, 0, 0, 0, 0, 1, 32'h020));
    tbl.push_back(row(0, 0, 0, 0, 0, 1, 32'h100));
    tbl.push_back(row(0, 0, 0, 0, 0, 1, 32'h104));
    // flush beats branch and stall
    tbl.push_back(row(1, 1, 32'h80, 1, 32'h200, 1, 32'h080));
    tbl.push_back(row(1, 0, 0, 0, 0, 1, 32'h080));
    tbl.push_back(row(0, 0, 0, 0, 0, 1, 32'h084));
    tbl.push_back(row(0, 0, 0, 0, 0, 1, 32'h088));
    // accepted branch, then overwrite of a pending branch
    tbl.push_back(row(0, 0, 0, 1, 32'h301, 1, 32'h300));
    tbl.push_back(row(0, 0, 0, 0, 0, 1, 32'h304));
    tbl.push_back(row(0, 0, 0, 1, 32'h400, 0, 32'h304));
    tbl.push_back(row(0, 0, 0, 1, 32'h500, 0, 32'h304));
    tbl.push_back(row(0, 0, 0, 0, 0, 1, 32'h500));
    // flush discards a pending branch
    tbl.push_back(row(1, 0, 0, 1, 32'h600, 1, 32'h500));
    tbl.push_back(row(1, 1, 32'h703, 0, 0, 0, 32'h700));
    tbl.push_back(row(0, 0, 0, 0, 0, 1, 32'h704));
    tbl.push_back(row(0, 0, 0, 0, 0, 1, 32'h708));

    // ---- clock/reset ----
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 3; k++) m[k] = model_reset();
    #3;
    chk("reset_pc", pc_a, 32'h0);
    chk("reset_ce", {31'b0, ce_a}, 32'h0);
    #9 rst = 1'b0;
    #1;
    chk("post_rst_ce_before_edge", {31'b0, ce_a}, 32'h0);
    chk_models();

    // ---- directed table ----
    foreach (tbl[i]) begin
      drive(tbl[i].st, tbl[i].fl, tbl[i].np, tbl[i].br, tbl[i].ba, tbl[i].rdy);
      tick();
      chk($sformatf("tbl%0d_pc", i), pc_a, tbl[i].exp_pc);
      chk($sformatf("tbl%0d_ce", i), {31'b0, ce_a}, {31'b0, tbl[i].exp_ce});
    end

    // ---- wrap and no-align variants ----
    drive(0, 1, 32'hFFFE, 0, 0, 1);
    tick();
    chk("wrap_b_load", {16'b0, pc_b}, 32'hFFFC);
    chk("wrap_c_load", {16'b0, pc_c}, 32'hFFFE);
    drive(0, 0, 0, 0, 0, 1);
    tick();
    chk("wrap_b", {16'b0, pc_b}, 32'h0000);
    chk("wrap_a_nowrap", pc_a, 32'h10000);
    chk("inc1_c", {16'b0, pc_c}, 32'hFFFF);
    tick();
    chk("wrap_c", {16'b0, pc_c}, 32'h0000);
    drive(0, 0, 0, 1, 32'h0003, 1);
    tick();
    chk("noalign_c", {16'b0, pc_c}, 32'h0003);
    chk("align_b", {16'b0, pc_b}, 32'h0000);

    // ---- async reset with a pending branch ----
    drive(1, 0, 0, 1, 32'h900, 1);
    tick();
    drive(1, 0, 0, 0, 0, 1);
    pulse_reset();
    drive(0, 0, 0, 0, 0, 1);
    tick();
    chk("after_rst_first", pc_a, 32'h0);
    chk("after_rst_ce", {31'b0, ce_a}, 32'h1);
    tick();
    chk("after_rst_no_pend", pc_a, 32'h4);

    // ---- randomized run against the model ----
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0, $urandom,
            $urandom_range(0, 3) == 0, $urandom, $urandom_range(0, 3) != 0);
      if ($urandom_range(0, 99) == 0) pulse_reset();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
